// File: rtl/fnd_pkg.sv
// Shared constants for the FND scan controller: glyph table and digit limits.
package fnd_pkg;

    // Upper bound on the number of multiplexed digits.
    localparam int MAX_DIGITS = 8;

    // Special digit codes beyond 0..9.
    localparam logic [3:0] CODE_MINUS = 4'hA;
    localparam logic [3:0] CODE_BLANK = 4'hF;

    // Active-low segment glyphs, bit7 = dp, bits6..0 = g..a.
    localparam logic [7:0] FONT_0     = 8'hC0;
    localparam logic [7:0] FONT_1     = 8'hF9;
    localparam logic [7:0] FONT_2     = 8'hA4;
    localparam logic [7:0] FONT_3     = 8'hB0;
    localparam logic [7:0] FONT_4     = 8'h99;
    localparam logic [7:0] FONT_5     = 8'h92;
    localparam logic [7:0] FONT_6     = 8'h82;
    localparam logic [7:0] FONT_7     = 8'hF8;
    localparam logic [7:0] FONT_8     = 8'h80;
    localparam logic [7:0] FONT_9     = 8'h90;
    localparam logic [7:0] FONT_MINUS = 8'hBF;
    localparam logic [7:0] FONT_BLANK = 8'hFF;

    // ANDing a glyph with this lights the decimal point (active-low bit7).
    localparam logic [7:0] DP_MASK    = 8'h7F;

endpackage

// File: rtl/fnd_font_rom.sv
// Combinational glyph lookup: 4-bit digit code plus dp request to an
// active-low 8-bit segment pattern.
module fnd_font_rom
    import fnd_pkg::*;
(
    input  logic [3:0] code,
    input  logic       dp,
    output logic [7:0] font
);

    logic [7:0] glyph;

    // Map the digit code to its glyph; unused codes show blank.
    always_comb begin
        // NOTE: the default arm gives glyph a value on every path, so no latch is inferred.
        case (code)
            4'd0:       glyph = FONT_0;
            4'd1:       glyph = FONT_1;
            4'd2:       glyph = FONT_2;
            4'd3:       glyph = FONT_3;
            4'd4:       glyph = FONT_4;
            4'd5:       glyph = FONT_5;
            4'd6:       glyph = FONT_6;
            4'd7:       glyph = FONT_7;
            4'd8:       glyph = FONT_8;
            4'd9:       glyph = FONT_9;
            CODE_MINUS: glyph = FONT_MINUS;
            default:    glyph = FONT_BLANK;
        endcase
    end

    assign font = dp ? (glyph & DP_MASK) : glyph;

endmodule

// File: rtl/fnd_scan_controller.sv
// Multiplexed 7-segment (FND) scan controller with double-buffered digit data,
// leading-zero suppression, ghost-suppression blanking and registered outputs.
module fnd_scan_controller
    import fnd_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int CLK_DIV        = 50000,
    parameter int BLANK_CYC      = 2,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit COM_ACTIVE_LOW = 1'b0
)(
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_en,
    input  logic                    i_load,
    input  logic [4*NUM_DIGITS-1:0] i_bcd,
    input  logic [NUM_DIGITS-1:0]   i_dp,
    input  logic                    i_lz_en,
    output logic [7:0]              o_fnd_font,
    output logic [NUM_DIGITS-1:0]   o_fnd_com,
    output logic                    o_frame_tick
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]      BLANK_END = CNT_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [7:0]            FONT_OFF  = {8{SEG_ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] COM_OFF   = {NUM_DIGITS{COM_ACTIVE_LOW}};

    if (NUM_DIGITS < 1 || NUM_DIGITS > MAX_DIGITS) begin : g_bad_digits
        $error("NUM_DIGITS out of range");
    end
    if (CLK_DIV < 2 || BLANK_CYC < 0 || BLANK_CYC >= CLK_DIV) begin : g_bad_timing
        $error("CLK_DIV/BLANK_CYC out of range");
    end

    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic                    slot_end;
    logic                    wrap;

    logic [4*NUM_DIGITS-1:0] pend_bcd;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic                    pend_flag;
    logic [4*NUM_DIGITS-1:0] act_bcd;
    logic [NUM_DIGITS-1:0]   act_dp;

    logic [NUM_DIGITS-1:0]   lz_mask;
    logic [3:0]              rom_code;
    logic [7:0]              rom_font;
    logic [NUM_DIGITS-1:0]   com_onehot;
    logic [7:0]              font_next;
    logic [NUM_DIGITS-1:0]   com_next;

    assign slot_end = (cnt == CNT_LAST);
    assign wrap     = slot_end && (idx == IDX_LAST);

    // Prescaler counts through one slot, then steps the digit index.
    always_ff @(posedge i_clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (i_reset) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Double buffer: loads park in the pending buffer and are promoted only at
    // the frame wrap, so a frame never mixes old and new digits.
    always_ff @(posedge i_clk) begin
        // NOTE: both buffers are explicitly cleared on reset so a stale pending load can never surface.
        if (i_reset) begin
            pend_bcd  <= '0;
            pend_dp   <= '0;
            pend_flag <= 1'b0;
            act_bcd   <= '0;
            act_dp    <= '0;
        end else if (wrap) begin
            if (i_load) begin
                act_bcd <= i_bcd;
                act_dp  <= i_dp;
            end else if (pend_flag) begin
                act_bcd <= pend_bcd;
                act_dp  <= pend_dp;
            end
            pend_flag <= 1'b0;
        end else if (i_load) begin
            pend_bcd  <= i_bcd;
            pend_dp   <= i_dp;
            pend_flag <= 1'b1;
        end
    end

    // Mark digits whose nibble and every more-significant nibble are zero.
    always_comb begin
        logic all_zero;
        all_zero = 1'b1;
        lz_mask  = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            all_zero = all_zero & (act_bcd[4*k +: 4] == 4'h0);
            if (k != 0) lz_mask[k] = all_zero & i_lz_en;
        end
    end

    assign rom_code = lz_mask[idx] ? CODE_BLANK : act_bcd[{idx, 2'b00} +: 4];

    fnd_font_rom u_font_rom (
        .code (rom_code),
        .dp   (act_dp[idx]),
        .font (rom_font)
    );

    // Build the next font/common drive, blanked while disabled or in the slot's guard interval.
    always_comb begin
        com_onehot      = '0;
        com_onehot[idx] = 1'b1;
        font_next       = FONT_OFF;
        com_next        = COM_OFF;
        if (i_en && (cnt >= BLANK_END)) begin
            font_next = rom_font ^ {8{~SEG_ACTIVE_LOW}};
            com_next  = com_onehot ^ COM_OFF;
        end
    end

    // Register the display outputs and the frame tick.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_fnd_font   <= FONT_OFF;
            o_fnd_com    <= COM_OFF;
            o_frame_tick <= 1'b0;
        end else begin
            o_fnd_font   <= font_next;
            o_fnd_com    <= com_next;
            o_frame_tick <= wrap;
        end
    end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Directed bench for fnd_scan_controller with NUM_DIGITS=4, CLK_DIV=4,
// BLANK_CYC=1, active-low segments and active-high commons.
module tb_fnd_scan_controller;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_en;
    logic        i_load;
    logic [15:0] i_bcd;
    logic [3:0]  i_dp;
    logic        i_lz_en;
    logic [7:0]  o_fnd_font;
    logic [3:0]  o_fnd_com;
    logic        o_frame_tick;

    int checks   = 0;
    int failures = 0;

    always #5 i_clk = ~i_clk;

    fnd_scan_controller #(
        .NUM_DIGITS     (4),
        .CLK_DIV        (4),
        .BLANK_CYC      (1),
        .SEG_ACTIVE_LOW (1'b1),
        .COM_ACTIVE_LOW (1'b0)
    ) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_en         (i_en),
        .i_load       (i_load),
        .i_bcd        (i_bcd),
        .i_dp         (i_dp),
        .i_lz_en      (i_lz_en),
        .o_fnd_font   (o_fnd_font),
        .o_fnd_com    (o_fnd_com),
        .o_frame_tick (o_frame_tick)
    );

    // Count one comparison and report it if it differs.
    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Advance one clock, settle past the edge, and drop any one-cycle load strobe.
    task automatic tick();
        @(posedge i_clk);
        #1;
        i_load = 1'b0;
    endtask

    // Check one 16-cycle frame starting just after a frame wrap.
    task automatic check_frame(input string tag, input logic [3:0][7:0] exp_font,
                               input int load_step, input logic [15:0] load_bcd,
                               input logic [3:0] load_dp, input int en_from, input int en_to);
        for (int s = 0; s < 16; s++) begin
            int         d;
            int         ph;
            logic [7:0] ef;
            logic [3:0] ec;
            logic       en_on;
            d     = s / 4;
            ph    = s % 4;
            en_on = !(s >= en_from && s <= en_to);
            i_en  = en_on;
            if (s == load_step) begin
                i_load = 1'b1;
                i_bcd  = load_bcd;
                i_dp   = load_dp;
            end
            tick();
            if (!en_on || ph == 0) begin
                ef = 8'hFF;
                ec = 4'b0000;
            end else begin
                ef = exp_font[d];
                ec = 4'b0001 << d;
            end
            check($sformatf("%s s%0d font", tag, s), 32'(o_fnd_font), 32'(ef));
            check($sformatf("%s s%0d com", tag, s), 32'(o_fnd_com), 32'(ec));
            check($sformatf("%s s%0d tick", tag, s), 32'(o_frame_tick), 32'(s == 15));
        end
        i_en = 1'b1;
    endtask

    initial begin
        i_reset = 1'b1;
        i_en    = 1'b1;
        i_load  = 1'b1;
        i_bcd   = 16'h9999;
        i_dp    = 4'hF;
        i_lz_en = 1'b0;

        // Reset wins over load and enable.
        tick();
        tick();
        tick();
        check("reset font", 32'(o_fnd_font), 32'h000000FF);
        check("reset com", 32'(o_fnd_com), 32'h0);
        check("reset tick", 32'(o_frame_tick), 32'h0);
        i_reset = 1'b0;

        // Frame 0 shows cleared buffers; 1234 loaded at its start.
        check_frame("f0", {8'hC0, 8'hC0, 8'hC0, 8'hC0}, 0, 16'h1234, 4'b0000, 99, 99);
        // 1234 displayed; 1111 queued mid-frame.
        check_frame("f1", {8'hF9, 8'hA4, 8'hB0, 8'h99}, 5, 16'h1111, 4'b0000, 99, 99);
        // 1111 frame completes untorn while 2222 is queued mid-frame.
        check_frame("f2", {8'hF9, 8'hF9, 8'hF9, 8'hF9}, 7, 16'h2222, 4'b0000, 99, 99);
        // 2222 frame; A000 presented exactly on the wrap cycle.
        check_frame("f3", {8'hA4, 8'hA4, 8'hA4, 8'hA4}, 15, 16'hA000, 4'b0000, 99, 99);
        // Minus appears immediately; queue 1234 with dp on digits 0 and 2.
        check_frame("f4", {8'hBF, 8'hC0, 8'hC0, 8'hC0}, 3, 16'h1234, 4'b0101, 99, 99);
        check_frame("f5", {8'hF9, 8'h24, 8'hB0, 8'h19}, 9, 16'h0050, 4'b0000, 99, 99);

        // Leading-zero suppression.
        i_lz_en = 1'b1;
        check_frame("f6", {8'hFF, 8'hFF, 8'h92, 8'hC0}, 2, 16'h0000, 4'b0010, 99, 99);
        check_frame("f7", {8'hFF, 8'hFF, 8'h7F, 8'hC0}, 10, 16'h1234, 4'b0000, 99, 99);
        // Display disabled for 10 cycles; tick spacing unchanged.
        check_frame("f8", {8'hF9, 8'hA4, 8'hB0, 8'h99}, -1, 16'h0, 4'b0000, 3, 12);
        i_lz_en = 1'b0;

        // Reset mid-slot with a pending load.
        tick();
        tick();
        tick();
        i_load = 1'b1;
        i_bcd  = 16'h8888;
        i_dp   = 4'hF;
        tick();
        tick();
        i_reset = 1'b1;
        i_load  = 1'b1;
        i_bcd   = 16'h7777;
        tick();
        check("midrst font", 32'(o_fnd_font), 32'h000000FF);
        check("midrst com", 32'(o_fnd_com), 32'h0);
        check("midrst tick", 32'(o_frame_tick), 32'h0);
        i_reset = 1'b0;
        check_frame("r0", {8'hC0, 8'hC0, 8'hC0, 8'hC0}, -1, 16'h0, 4'b0000, 99, 99);
        check_frame("r1", {8'hC0, 8'hC0, 8'hC0, 8'hC0}, -1, 16'h0, 4'b0000, 99, 99);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fnd_scan_controller.md
FND_SCAN_CONTROLLER -- requirements
Module: fnd_scan_controller

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digits, 1..8.
REQ-002 Parameter CLK_DIV, default 50000: clock cycles per digit slot, at least 2.
REQ-003 Parameter BLANK_CYC, default 2: cycles at the start of each slot with all commons off (ghost suppression), 0..CLK_DIV-1.
REQ-004 Parameter SEG_ACTIVE_LOW, default 1: 1 means segment outputs are active-low.
REQ-005 Parameter COM_ACTIVE_LOW, default 0: 1 means common outputs are active-low.
REQ-006 i_clk  in  1  single clock; all logic is on its rising edge.
REQ-007 i_reset  in  1  synchronous, active-high reset.
REQ-008 i_en  in  1  display enable; 0 blanks all outputs.
REQ-009 i_load  in  1  one-cycle strobe that captures i_bcd and i_dp.
REQ-010 i_bcd  in  4*NUM_DIGITS  digit codes; nibble k is digit k, and digit 0 is least significant.
REQ-011 i_dp  in  NUM_DIGITS  decimal point request per digit.
REQ-012 i_lz_en  in  1  leading-zero suppression enable.
REQ-013 o_fnd_font  out  8  segment pattern; bit7 = dp, bits6..0 = g..a.
REQ-014 o_fnd_com  out  NUM_DIGITS  one-hot digit select.
REQ-015 o_frame_tick  out  1  one-cycle pulse when the scan wraps to digit 0.

Function
REQ-016 The prescaler shall count 0..CLK_DIV-1; at terminal count it shall return to 0 and advance the digit index by 1.
REQ-017 The digit index shall wrap from NUM_DIGITS-1 to 0; o_frame_tick shall be 1 for exactly the cycle after that wrap.
REQ-018 The active-low font table shall be: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, 10=BF (minus), 11..15=FF (blank).
REQ-019 When digit k is displayed with i_dp[k]=1, bit7 shall be driven active.
REQ-020 With SEG_ACTIVE_LOW=0, o_fnd_font shall be the bitwise inverse of the active-low pattern.
REQ-021 On i_load=1, i_bcd and i_dp shall be captured into a pending buffer and a pending flag shall be set.
REQ-022 At the wrap cycle, pending data shall move to the active buffer and the flag shall clear.
REQ-023 If i_load coincides with the wrap cycle, the newly presented data shall go directly to the active buffer and the flag shall clear.
REQ-024 Displayed data shall change only at frame boundaries (no tearing).
REQ-025 With i_lz_en=1, digit k (k>0) shall show blank segments when every active nibble from NUM_DIGITS-1 down to k equals 0.
REQ-026 Digit 0 shall never be suppressed.
REQ-027 The dp of a suppressed digit shall still be shown if requested.
REQ-028 During the first BLANK_CYC cycles of each slot, o_fnd_com shall be all inactive and o_fnd_font all off.
REQ-029 For the rest of each slot, o_fnd_com shall have only the current digit active.
REQ-030 o_fnd_font and o_fnd_com shall be registered: one cycle latency from prescaler/index state.
REQ-031 With i_en=0, o_fnd_font and o_fnd_com shall be all off one cycle later.
REQ-032 With i_en=0, the prescaler, digit index, o_frame_tick and load handling shall keep running.

Reset
REQ-033 On i_reset=1 at a clock edge, prescaler=0, digit index=0, pending flag=0 and both buffers=0.
REQ-034 On reset, o_frame_tick shall be 0 and o_fnd_font and o_fnd_com shall be all off (polarity per parameters).
REQ-035 i_reset shall take priority over i_load and i_en.
REQ-036 A reset mid-slot shall discard any pending load.

Structure
REQ-037 A shared package fnd_pkg shall hold the font table constants (including the minus and blank codes) and the maximum-digit constant.
REQ-038 The single sub-module shall be fnd_font_rom (combinational 4-bit code plus dp to 8-bit active-low font), instantiated once on the selected digit.

Verification (NUM_DIGITS=4, CLK_DIV=4, BLANK_CYC=1, active-low segments, active-high commons)
REQ-039 Scan: load 16'h1234, dp=0 -> com sequence 0000,0001 x3,0000,0010 x3,...; fonts F9 on digit3-slot and 99 on digit0-slot; frame_tick every 16 cycles.
REQ-040 LZ: i_lz_en=1, load 16'h0050 -> digits 3,2 show FF, digit1 = 92, digit0 = C0; load 16'h0000 -> only digit0 shows C0.
REQ-041 Double buffer: load 16'h1111 then 16'h2222 mid-frame -> current frame completes with F9, next frame shows A4 on all digits.
REQ-042 Coincident load at the wrap cycle with 16'hA000 -> the next frame shows digit3 = BF immediately.
REQ-043 i_en=0 for 10 cycles -> font FF and com 0000 one cycle later; frame_tick spacing is unchanged.
REQ-044 Reset asserted mid-slot with a pending load -> next cycle all outputs off, index 0; the old pending data is never displayed.
